siganfu_target_lock: RTL and testbench



---
 rtl/siganfu_target_lock.sv | 198 +++++++++++++++++++
 tb/tb_siganfu_target_lock.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/siganfu_target_lock.sv
// Target acquisition/lock FSM feeding the machine-gun controller: qualifies radar
// frames, runs the IFF handshake, and holds lock through short dropouts.
module siganfu_target_lock #(
  parameter int ACQ_HITS     = 4,
  parameter int COAST_MISSES = 3,
  parameter int IFF_TIMEOUT  = 16,
  parameter int MAX_RANGE    = 200
) (
  input  logic       sysclk,
  input  logic       reboot_n,
  input  logic       contact_valid,
  input  logic       contact_present,
  input  logic [7:0] contact_range,
  input  logic       lock_release,
  input  logic       iff_ack,
  input  logic       iff_friend,
  output logic       target_locked,
  output logic       is_enemy,
  output logic [2:0] lock_state,
  output logic       iff_query,
  output logic [7:0] locked_range,
  output logic       lost_pulse
);

  typedef enum logic [2:0] {
    ST_SEARCH      = 3'd0,
    ST_TRACK       = 3'd1,
    ST_INTERROGATE = 3'd2,
    ST_LOCKED      = 3'd3,
    ST_COAST       = 3'd4,
    ST_FRIEND      = 3'd5
  } state_e;

  localparam logic [3:0] ACQ_C     = 4'(ACQ_HITS);
  localparam logic [3:0] COAST_C   = 4'(COAST_MISSES);
  localparam logic [7:0] TIMEOUT_C = 8'(IFF_TIMEOUT - 1);
  localparam logic [7:0] RANGE_C   = 8'(MAX_RANGE);

  state_e     state_q, state_d;
  logic [3:0] hit_cnt_q, hit_cnt_d;
  logic [3:0] miss_cnt_q, miss_cnt_d;
  logic [7:0] iff_cnt_q, iff_cnt_d;
  logic [7:0] locked_range_q, locked_range_d;
  logic       iff_query_q, iff_query_d;
  logic       lost_pulse_q, lost_pulse_d;
  logic       target_locked_q, target_locked_d;
  logic       is_enemy_q, is_enemy_d;

  logic hit;
  logic miss;

  assign hit  = contact_valid & contact_present & (contact_range <= RANGE_C);
  assign miss = contact_valid & ~hit;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path infers a latch.
    state_d        = state_q;
    hit_cnt_d      = hit_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    iff_cnt_d      = iff_cnt_q;
    locked_range_d = locked_range_q;
    iff_query_d    = 1'b0;
    lost_pulse_d   = 1'b0;

    if (lock_release) begin
      state_d    = ST_SEARCH;
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
      iff_cnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_SEARCH: begin
          if (hit) begin
            state_d        = ST_TRACK;
            hit_cnt_d      = 4'd1;
            locked_range_d = contact_range;
          end
        end

        ST_TRACK: begin
          if (hit) begin
            locked_range_d = contact_range;
            if (hit_cnt_q + 4'd1 == ACQ_C) begin
              state_d     = ST_INTERROGATE;
              hit_cnt_d   = '0;
              iff_cnt_d   = '0;
              iff_query_d = 1'b1;
            end else begin
              hit_cnt_d = hit_cnt_q + 4'd1;
            end
          end else if (miss) begin
            state_d   = ST_SEARCH;
            hit_cnt_d = '0;
          end
        end

        // A miss beats a same-cycle ack: the contact is gone, so its verdict is moot.
        ST_INTERROGATE: begin
          iff_cnt_d = iff_cnt_q + 8'd1;
          if (miss) begin
            state_d   = ST_SEARCH;
            iff_cnt_d = '0;
          end else if (iff_ack) begin
            state_d    = iff_friend ? ST_FRIEND : ST_LOCKED;
            iff_cnt_d  = '0;
            miss_cnt_d = '0;
          end else if (iff_cnt_q == TIMEOUT_C) begin
            state_d   = ST_SEARCH;
            iff_cnt_d = '0;
          end
        end

        ST_LOCKED: begin
          if (hit) begin
            locked_range_d = contact_range;
            miss_cnt_d     = '0;
          end else if (miss) begin
            if (COAST_C == 4'd1) begin
              state_d      = ST_SEARCH;
              miss_cnt_d   = '0;
              lost_pulse_d = 1'b1;
            end else begin
              state_d    = ST_COAST;
              miss_cnt_d = 4'd1;
            end
          end
        end

        ST_COAST: begin
          if (hit) begin
            state_d        = ST_LOCKED;
            locked_range_d = contact_range;
            miss_cnt_d     = '0;
          end else if (miss) begin
            if (miss_cnt_q + 4'd1 == COAST_C) begin
              state_d      = ST_SEARCH;
              miss_cnt_d   = '0;
              lost_pulse_d = 1'b1;
            end else begin
              miss_cnt_d = miss_cnt_q + 4'd1;
            end
          end
        end

        ST_FRIEND: begin
          if (miss) begin
            state_d = ST_SEARCH;
          end
        end

        default: begin
          state_d    = ST_SEARCH;
          hit_cnt_d  = '0;
          miss_cnt_d = '0;
          iff_cnt_d  = '0;
        end
      endcase
    end

    // Outputs decode the next state so they change on the same edge as lock_state.
    target_locked_d = (state_d == ST_LOCKED) || (state_d == ST_COAST);
    is_enemy_d      = (state_d == ST_LOCKED) || (state_d == ST_COAST);
  end

  always_ff @(posedge sysclk) begin
    if (!reboot_n) begin
      // NOTE: locked_range is reset too; the gun controller must never see a stale range after reboot.
      state_q         <= ST_SEARCH;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
      iff_cnt_q       <= '0;
      locked_range_q  <= '0;
      iff_query_q     <= 1'b0;
      lost_pulse_q    <= 1'b0;
      target_locked_q <= 1'b0;
      is_enemy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of its neighbours.
      state_q         <= state_d;
      hit_cnt_q       <= hit_cnt_d;
      miss_cnt_q      <= miss_cnt_d;
      iff_cnt_q       <= iff_cnt_d;
      locked_range_q  <= locked_range_d;
      iff_query_q     <= iff_query_d;
      lost_pulse_q    <= lost_pulse_d;
      target_locked_q <= target_locked_d;
      is_enemy_q      <= is_enemy_d;
    end
  end

  assign target_locked = target_locked_q;
  assign is_enemy      = is_enemy_q;
  assign lock_state    = state_q;
  assign iff_query     = iff_query_q;
  assign locked_range  = locked_range_q;
  assign lost_pulse    = lost_pulse_q;

endmodule

// File: tb/tb_siganfu_target_lock.sv
// Scoreboard bench for siganfu_target_lock: each scenario queues per-cycle stimulus
// with hand-derived expected outputs, then drives and compares them cycle by cycle.
module tb_siganfu_target_lock;

  logic       sysclk;
  logic       reboot_n;
  logic       contact_valid;
  logic       contact_present;
  logic [7:0] contact_range;
  logic       lock_release;
  logic       iff_ack;
  logic       iff_friend;
  logic       target_locked;
  logic       is_enemy;
  logic [2:0] lock_state;
  logic       iff_query;
  logic [7:0] locked_range;
  logic       lost_pulse;

  siganfu_target_lock dut (
    .sysclk          (sysclk),
    .reboot_n        (reboot_n),
    .contact_valid   (contact_valid),
    .contact_present (contact_present),
    .contact_range   (contact_range),
    .lock_release    (lock_release),
    .iff_ack         (iff_ack),
    .iff_friend      (iff_friend),
    .target_locked   (target_locked),
    .is_enemy        (is_enemy),
    .lock_state      (lock_state),
    .iff_query       (iff_query),
    .locked_range    (locked_range),
    .lost_pulse      (lost_pulse)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  typedef struct packed {
    logic       rst_n;
    logic       cv;
    logic       cp;
    logic [7:0] rng;
    logic       rel;
    logic       ack;
    logic       fr;
  } stim_t;

  typedef struct packed {
    logic       tl;
    logic       en;
    logic [2:0] st;
    logic       q;
    logic [7:0] rng;
    logic       lost;
  } exp_t;

  stim_t stim_q[$];
  exp_t  sb_q[$];
  int    total = 0;
  int    bad   = 0;

  function automatic stim_t idle();
    return '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
  endfunction
  function automatic stim_t hit(input logic [7:0] r);
    return '{1'b1, 1'b1, 1'b1, r, 1'b0, 1'b0, 1'b0};
  endfunction
  function automatic stim_t miss();
    return '{1'b1, 1'b1, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0};
  endfunction
  function automatic stim_t ack(input logic fr);
    return '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, fr};
  endfunction
  function automatic stim_t rel();
    return '{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
  endfunction
  function automatic stim_t rst();
    return '{1'b0, 1'b1, 1'b1, 8'd33, 1'b0, 1'b0, 1'b0};
  endfunction

  // Gun-facing flags are high exactly in LOCKED (3) and COAST (4).
  function automatic exp_t e(input int st, input logic q, input logic [7:0] r, input logic lost);
    exp_t x;
    x.tl   = (st == 3) || (st == 4);
    x.en   = (st == 3) || (st == 4);
    x.st   = 3'(st);
    x.q    = q;
    x.rng  = r;
    x.lost = lost;
    return x;
  endfunction

  function automatic exp_t observe();
    return '{target_locked, is_enemy, lock_state, iff_query, locked_range, lost_pulse};
  endfunction

  function automatic string fmt(input exp_t x);
    return $sformatf("st=%0d tl=%b en=%b q=%b rng=%0d lost=%b", x.st, x.tl, x.en, x.q, x.rng, x.lost);
  endfunction

  task automatic add(input stim_t s, input exp_t x);
    stim_q.push_back(s);
    sb_q.push_back(x);
  endtask

  task automatic drive(input stim_t s);
    reboot_n        = s.rst_n;
    contact_valid   = s.cv;
    contact_present = s.cp;
    contact_range   = s.rng;
    lock_release    = s.rel;
    iff_ack         = s.ack;
    iff_friend      = s.fr;
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    exp_t want, got;
    add(rst(), e(0, 0, 0, 0));
    add(rst(), e(0, 0, 0, 0));
    add(idle(), e(0, 0, 0, 0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front());
      want = sb_q.pop_front();
      got  = observe();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset[%0d] got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_acquire();
    exp_t want, got;
    add(hit(120), e(1, 0, 120, 0));
    add(hit(120), e(1, 0, 120, 0));
    add(hit(120), e(1, 0, 120, 0));
    add(hit(120), e(2, 1, 120, 0));
    add(idle(),   e(2, 0, 120, 0));
    add(idle(),   e(2, 0, 120, 0));
    add(ack(0),   e(3, 0, 120, 0));
    add(idle(),   e(3, 0, 120, 0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front());
      want = sb_q.pop_front();
      got  = observe();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL acquire[%0d] got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_range_gate();
    exp_t want, got;
    add(rel(),    e(0, 0, 120, 0));
    add(hit(50),  e(1, 0, 50, 0));
    add(hit(200), e(1, 0, 200, 0));
    add(hit(201), e(0, 0, 200, 0));
    add(hit(10),  e(1, 0, 10, 0));
    add(idle(),   e(1, 0, 10, 0));
    add(hit(10),  e(1, 0, 10, 0));
    add(hit(10),  e(1, 0, 10, 0));
    add(hit(10),  e(2, 1, 10, 0));
    add(miss(),   e(0, 0, 10, 0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front());
      want = sb_q.pop_front();
      got  = observe();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL range_gate[%0d] got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_coast();
    exp_t want, got;
    for (int k = 1; k <= 3; k++) add(hit(90), e(1, 0, 90, 0));
    add(hit(90), e(2, 1, 90, 0));
    add(ack(0),  e(3, 0, 90, 0));
    add(miss(),  e(4, 0, 90, 0));
    add(miss(),  e(4, 0, 90, 0));
    add(hit(80), e(3, 0, 80, 0));
    add(miss(),  e(4, 0, 80, 0));
    add(miss(),  e(4, 0, 80, 0));
    add(miss(),  e(0, 0, 80, 1));
    add(idle(),  e(0, 0, 80, 0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front());
      want = sb_q.pop_front();
      got  = observe();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL coast[%0d] got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_iff_edges();
    exp_t  want, got;
    stim_t both;
    // Friendly reply, then hits and a stray ack are ignored until a miss.
    for (int k = 1; k <= 3; k++) add(hit(60), e(1, 0, 60, 0));
    add(hit(60), e(2, 1, 60, 0));
    add(ack(1),  e(5, 0, 60, 0));
    add(hit(70), e(5, 0, 60, 0));
    add(ack(0),  e(5, 0, 60, 0));
    add(miss(),  e(0, 0, 60, 0));
    // Silent IFF: 15 cycles in INTERROGATE, SEARCH on the 16th edge.
    for (int k = 1; k <= 3; k++) add(hit(30), e(1, 0, 30, 0));
    add(hit(30), e(2, 1, 30, 0));
    for (int k = 1; k <= 15; k++) add((k % 3 == 0) ? hit(99) : idle(), e(2, 0, 30, 0));
    add(idle(), e(0, 0, 30, 0));
    // Ack coinciding with a miss.
    for (int k = 1; k <= 3; k++) add(hit(40), e(1, 0, 40, 0));
    add(hit(40), e(2, 1, 40, 0));
    both = miss();
    both.ack = 1'b1;
    add(both, e(0, 0, 40, 0));
    // Ack accepted in the very first INTERROGATE cycle.
    for (int k = 1; k <= 3; k++) add(hit(45), e(1, 0, 45, 0));
    add(hit(45), e(2, 1, 45, 0));
    add(ack(0),  e(3, 0, 45, 0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front());
      want = sb_q.pop_front();
      got  = observe();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL iff_edges[%0d] got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_release_reset();
    exp_t  want, got;
    stim_t last;
    // Starts LOCKED at range 45.
    add(miss(), e(4, 0, 45, 0));
    add(rel(),  e(0, 0, 45, 0));
    add(idle(), e(0, 0, 45, 0));
    for (int k = 1; k <= 3; k++) add(hit(77), e(1, 0, 77, 0));
    add(hit(77), e(2, 1, 77, 0));
    add(idle(),  e(2, 0, 77, 0));
    add(rst(),   e(0, 0, 0, 0));
    add(ack(0),  e(0, 0, 0, 0));
    for (int k = 1; k <= 3; k++) add(hit(77), e(1, 0, 77, 0));
    add(hit(77), e(2, 1, 77, 0));
    add(rel(),   e(0, 0, 77, 0));
    // Release on the final acquisition hit suppresses the query.
    for (int k = 1; k <= 3; k++) add(hit(20), e(1, 0, 20, 0));
    last = hit(20);
    last.rel = 1'b1;
    add(last,   e(0, 0, 20, 0));
    add(idle(), e(0, 0, 20, 0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front());
      want = sb_q.pop_front();
      got  = observe();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL release_reset[%0d] got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  initial begin
    reboot_n        = 1'b0;
    contact_valid   = 1'b0;
    contact_present = 1'b0;
    contact_range   = 8'd0;
    lock_release    = 1'b0;
    iff_ack         = 1'b0;
    iff_friend      = 1'b0;
    @(negedge sysclk);
    test_reset();
    test_acquire();
    test_range_gate();
    test_coast();
    test_iff_edges();
    test_release_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
